csr_bank: RTL

//  Parametrised bank of NumRegs control/status registers behind one request port.

---
 rtl/csr_bank.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/csr_bank.sv
// ---------------------------------------------------------------------------
// csr_bank
//   Bank of NumRegs control/status registers behind a single request port.
//   Each accepted request (read / write / set-bits / clear-bits) is answered
//   exactly one cycle later. The response carries the register value from
//   before the update. Per-bit write masks keep unwritable bits at their
//   reset value forever.
//   With ShadowCopy=1 every register also has an inverted shadow copy. The
//   shadow is checked on every in-range request and by a background
//   scrubber that visits one register every ScrubPeriod+1 cycles.
//
// Ports
//   clk, rst_n       clock, synchronous active-low reset
//   req_i            request valid (accepted every cycle, no backpressure)
//   req_op_i         00 read, 01 write, 10 set (OR), 11 clear (AND-NOT)
//   req_addr_i       register index
//   req_wdata_i      write data, or the bit mask for set / clear
//   rsp_valid_o      response valid, one cycle after req_i
//   rsp_rdata_o      pre-update value of the addressed register
//   rsp_err_o        out-of-range address, or shadow mismatch on access
//   csr_q_o          live register contents, slice i = register i
//   integrity_err_o  sticky shadow-mismatch flag
//   err_addr_o       index of the first mismatch since the last clear
//   err_clr_i        clears integrity_err_o and err_addr_o
// ---------------------------------------------------------------------------
module csr_bank #(
    parameter int unsigned                NumRegs     = 8,
    parameter int unsigned                Width       = 32,
    parameter bit                         ShadowCopy  = 1'b1,
    parameter logic [NumRegs*Width-1:0]   ResetValues = '0,
    parameter logic [NumRegs*Width-1:0]   WrMask      = '1,
    parameter int unsigned                ScrubPeriod = 16,
    localparam int unsigned               AddrW       = $clog2(NumRegs)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_i,
    input  logic [1:0]               req_op_i,
    input  logic [AddrW-1:0]         req_addr_i,
    input  logic [Width-1:0]         req_wdata_i,
    output logic                     rsp_valid_o,
    output logic [Width-1:0]         rsp_rdata_o,
    output logic                     rsp_err_o,
    output logic [NumRegs*Width-1:0] csr_q_o,
    output logic                     integrity_err_o,
    output logic [AddrW-1:0]         err_addr_o,
    input  logic                     err_clr_i
);

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_SET   = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    logic [Width-1:0] rst_val [NumRegs];
    logic [Width-1:0] wr_mask [NumRegs];
    logic [Width-1:0] regs_q  [NumRegs];
    logic [Width-1:0] regs_d  [NumRegs];

    logic             rsp_valid_q, rsp_valid_d;
    logic [Width-1:0] rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q,   rsp_err_d;

    logic             addr_ok;
    logic [AddrW-1:0] acc_idx;
    logic [Width-1:0] old_val;
    logic [Width-1:0] new_val;
    logic [Width-1:0] stored_val;
    logic             do_upd;
    logic             rd_mismatch;

    for (genvar g = 0; g < NumRegs; g++) begin : g_slice
        assign rst_val[g]                 = ResetValues[g*Width +: Width];
        assign wr_mask[g]                 = WrMask[g*Width +: Width];
        assign csr_q_o[g*Width +: Width]  = regs_q[g];
    end

    // Request decode and register update.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        addr_ok  = (32'(req_addr_i) < NumRegs);
        // Out-of-range addresses are steered to index 0 so the array is never
        // indexed past its end; do_upd and the response mux ignore that value.
        acc_idx  = addr_ok ? req_addr_i : '0;
        old_val  = regs_q[acc_idx];
        new_val  = old_val;
        case (op_e'(req_op_i))
            OP_WRITE: new_val = req_wdata_i;
            OP_SET:   new_val = old_val | req_wdata_i;
            OP_CLEAR: new_val = old_val & ~req_wdata_i;
            default:  new_val = old_val;
        endcase
        stored_val = (old_val & ~wr_mask[acc_idx]) | (new_val & wr_mask[acc_idx]);
        do_upd     = req_i && addr_ok && (op_e'(req_op_i) != OP_READ);
        regs_d     = regs_q;
        if (do_upd) begin
            regs_d[acc_idx] = stored_val;
        end
    end

    always_comb begin
        rsp_valid_d = req_i;
        rsp_rdata_d = (req_i && addr_ok) ? old_val : '0;
        rsp_err_d   = req_i && (!addr_ok || rd_mismatch);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the register array is reset element by element because consumers read it live.
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= rst_val[i];
            end
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignment so every flop samples pre-edge values.
            regs_q      <= regs_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

    if (ShadowCopy) begin : g_shadow
        localparam int unsigned CntW = $clog2(ScrubPeriod + 1);

        typedef enum logic {
            SCRUB_WAIT  = 1'b0,
            SCRUB_CHECK = 1'b1
        } scrub_state_e;

        logic [Width-1:0] shadow_q [NumRegs];
        logic [Width-1:0] shadow_d [NumRegs];
        scrub_state_e     state_q, state_d;
        logic [CntW-1:0]  cnt_q, cnt_d;
        logic [AddrW-1:0] idx_q, idx_d;
        logic             integ_q, integ_d;
        logic [AddrW-1:0] err_addr_q, err_addr_d;
        logic             scrub_mismatch;

        // The shadow follows every stored value, so a write also repairs a
        // corrupted shadow entry.
        always_comb begin
            shadow_d = shadow_q;
            if (do_upd) begin
                shadow_d[acc_idx] = ~stored_val;
            end
        end

        assign rd_mismatch = req_i && addr_ok && (old_val != ~shadow_q[acc_idx]);

        // Scrubber: ScrubPeriod cycles in WAIT, then one CHECK cycle.
        always_comb begin
            state_d        = state_q;
            cnt_d          = cnt_q;
            idx_d          = idx_q;
            scrub_mismatch = 1'b0;
            case (state_q)
                SCRUB_WAIT: begin
                    if (cnt_q == CntW'(ScrubPeriod - 1)) begin
                        state_d = SCRUB_CHECK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                SCRUB_CHECK: begin
                    scrub_mismatch = (regs_q[idx_q] != ~shadow_q[idx_q]);
                    idx_d          = (idx_q == AddrW'(NumRegs - 1)) ? '0 : idx_q + AddrW'(1);
                    state_d        = SCRUB_WAIT;
                    cnt_d          = '0;
                end
                default: state_d = SCRUB_WAIT;
            endcase
        end

        // Error capture: a new mismatch beats a simultaneous clear, and the
        // read-check address beats the scrubber address.
        always_comb begin
            integ_d    = integ_q;
            err_addr_d = err_addr_q;
            if (err_clr_i) begin
                integ_d    = 1'b0;
                err_addr_d = '0;
            end
            if (rd_mismatch || scrub_mismatch) begin
                integ_d = 1'b1;
                if (!integ_q || err_clr_i) begin
                    err_addr_d = rd_mismatch ? req_addr_i : idx_q;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int i = 0; i < NumRegs; i++) begin
                    shadow_q[i] <= ~rst_val[i];
                end
                state_q    <= SCRUB_WAIT;
                cnt_q      <= '0;
                idx_q      <= '0;
                integ_q    <= 1'b0;
                err_addr_q <= '0;
            end else begin
                shadow_q   <= shadow_d;
                state_q    <= state_d;
                cnt_q      <= cnt_d;
                idx_q      <= idx_d;
                integ_q    <= integ_d;
                err_addr_q <= err_addr_d;
            end
        end

        assign integrity_err_o = integ_q;
        assign err_addr_o      = err_addr_q;
    end else begin : g_no_shadow
        assign rd_mismatch     = 1'b0;
        assign integrity_err_o = 1'b0;
        assign err_addr_o      = '0;
    end

endmodule
